serial_deserializer: RTL
========================

SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles per serial bit; the value SHALL be even and >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 serial_in  input  1  serial line: idle high; frame is 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); synchronous to clk.
REQ-005 data  output  8  last correctly received byte; intended to drive the d input of the downstream 8-bit register.
REQ-006 valid  output  1  one-cycle pulse marking a new byte on data; intended to drive that register's enable.
REQ-007 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 FSM states SHALL be IDLE, START, DATA, STOP, with a bit counter cnt (0..CLKS_PER_BIT-1) and bit index idx (0..7).
REQ-010 IDLE: serial_in==0 at an edge (detection edge, t=0) -> START, cnt=0; otherwise stay in IDLE.
REQ-011 START: at t=H, where H=CLKS_PER_BIT/2, sample serial_in: 0 -> DATA with cnt=0, idx=0; 1 -> IDLE (glitch rejected, no outputs pulsed).
REQ-012 DATA: each time cnt reaches CLKS_PER_BIT-1, sample serial_in, shift right into the internal shift register (new bit enters bit 7), clear cnt, increment idx.
REQ-013 Data samples SHALL occur at t = H + k*CLKS_PER_BIT for k=1..8; after sample 8, the FSM SHALL go to STOP.
REQ-014 STOP: sample at t = H + 9*CLKS_PER_BIT (38 for default).
REQ-015 Stop bit 1 -> data loads the shift register and valid=1 for exactly that one cycle.
REQ-016 Stop bit 0 -> frame_err=1 for one cycle and data holds its previous value.
REQ-017 After the STOP sample, the FSM SHALL return to IDLE in either case.
REQ-018 valid and frame_err SHALL never be high in the same cycle, and each SHALL deassert on the following edge.
REQ-019 data SHALL change only on a valid pulse; it is stable at all other times, including during reception.
REQ-020 Back-to-back frames: a start bit immediately after a single stop bit SHALL be detected, with no extra idle cycles required.
REQ-021 serial_in transitions inside a bit period other than at the sample points SHALL have no effect.
REQ-022 busy SHALL be 1 from the edge after detection through the STOP sample edge, and 0 in IDLE.

Reset
REQ-023 reset=1 at an edge SHALL force state=IDLE, cnt=0, idx=0, shift register=0x00, data=0x00, valid=0, frame_err=0, busy=0.
REQ-024 reset SHALL take priority over all FSM activity, including mid-frame; the partial frame is discarded with no valid and no frame_err.
REQ-025 After reset deasserts, the first low sample on serial_in SHALL start a new frame.

Verification
REQ-026 CLKS_PER_BIT=4, frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop bit 1 -> valid pulse 38 cycles after detection, data=0xA5, frame_err=0.
REQ-027 Send 0x3C, then 0x77 with stop bit 0 -> frame_err one-cycle pulse, valid=0, data remains 0x3C.
REQ-028 serial_in low for 1 cycle, then high -> FSM returns to IDLE after the START sample; no valid, no frame_err, data unchanged.
REQ-029 Frames 0x00 then 0xFF back-to-back, single stop bits -> two valid pulses 40 cycles apart, data=0x00 then 0xFF.
REQ-030 reset asserted after the 4th data bit of 0x5A, then 0xC3 sent -> outputs 0 during reset, no pulse for 0x5A, data=0xC3 with one valid pulse.
REQ-031 Repeat REQ-026 with CLKS_PER_BIT=16 -> valid pulse 152 cycles after detection, data=0xA5.

Source files
------------

// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Receives 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) on
//   an idle-high line that is synchronous to clk.  The start bit is
//   confirmed at mid-bit, and each later bit is sampled one bit period
//   after the previous sample.  A byte is published only when its stop bit
//   reads 1.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (even, >= 2)
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high
//   serial_in : serial line, idle high
//   data      : last correctly received byte; changes only with valid
//   valid     : one-cycle pulse, new byte on data
//   frame_err : one-cycle pulse, stop bit sampled as 0
//   busy      : receiver is not idle
module serial_deserializer #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!serial_in) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         // The detection edge already counts as cycle 0 of the start bit, so
         // the mid-bit sample falls when cnt reaches CLKS_PER_BIT/2-1.
         START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (!serial_in) begin
                  state_d = DATA;
                  idx_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         DATA: begin
            if (cnt_q == CNT_LAST) begin
               shift_d = {serial_in, shift_q[7:1]};
               cnt_d   = '0;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
               if (serial_in) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule
